// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg: shared types for the memory fill engine.
// Provides the pattern-mode and FSM-state encodings used by mem_fill_engine
// and mem_fill_pattern. No ports; imported with mem_fill_pkg::*.
package mem_fill_pkg;

  // Pattern mode encodings as seen on the mode input.
  localparam logic [1:0] MODE_IDENT = 2'b00;
  localparam logic [1:0] MODE_CONST = 2'b01;
  localparam logic [1:0] MODE_DESC  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  // FSM state encodings.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_VRFY   = 3'd2;
  localparam logic [2:0] ST_VDRAIN = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [1:0] {
    IDENT = MODE_IDENT,
    CONST = MODE_CONST,
    DESC  = MODE_DESC,
    RSVD  = MODE_RSVD
  } fill_mode_t;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FILL   = ST_FILL,
    VRFY   = ST_VRFY,
    VDRAIN = ST_VDRAIN,
    DONE   = ST_DONE
  } fill_state_t;

endpackage

// File: rtl/mem_fill_pattern.sv
// mem_fill_pattern: expected RAM word for counter index idx.
// Latency: purely combinational. Backpressure: none.
// Ports: idx (counter), mode (latched pattern), fill_value (latched constant),
// word (pattern value). Values are formed at ADDR_W bits then resized to DATA_W.
module mem_fill_pattern
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic [ADDR_W-1:0] idx,
  input  fill_mode_t        mode,
  input  logic [DATA_W-1:0] fill_value,
  output logic [DATA_W-1:0] word
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  always_comb begin
    word = DATA_W'(idx);
    case (mode)
      CONST:   word = fill_value;
      DESC:    word = DATA_W'(LAST - idx);
      default: word = DATA_W'(idx);   // IDENT and the reserved code
    endcase
  end

endmodule

// File: rtl/mem_fill_engine.sv
// mem_fill_engine: writes an IDENT/CONST/DESC pattern to DEPTH RAM words, one per clock.
// Latency: first write the cycle after start; done DEPTH+1 cycles after start
// (2*DEPTH+2 with read-back verify). Backpressure: none; start is ignored while busy.
// Ports: clk, reset_task (async, active high), start/abort control, mode/fill_value
// (latched on start), q (RAM read data, 1-cycle latency), address/data/write_enable
// to the RAM, busy/done status, error/err_addr verify result.
// Optional feature: define MEM_FILL_VERIFY_EN to compile in the read-back verify pass.
module mem_fill_engine
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_task,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              write_enable,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  fill_state_t       state;
  logic [ADDR_W-1:0] i;
  fill_mode_t        mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] pat_idx;
  logic [DATA_W-1:0] pat_word;
  logic              at_last;

  assign at_last = (i == LAST);

  // i is returned to 0 on every exit from FILL/VRFY, so it idles at 0 and
  // can drive the address port directly.
  always_ff @(posedge clk or posedge reset_task) begin
    if (reset_task) begin
      state  <= IDLE;
      i      <= '0;
      mode_q <= IDENT;
      fill_q <= '0;
    end else if (abort) begin
      // abort outranks every transition, including a start in IDLE
      state <= IDLE;
      i     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= FILL;
            i      <= '0;
            mode_q <= fill_mode_t'(mode);
            fill_q <= fill_value;
          end
        end
        FILL: begin
          if (at_last) begin
            i     <= '0;
`ifdef MEM_FILL_VERIFY_EN
            state <= VRFY;
`else
            state <= DONE;
`endif
          end else begin
            i <= i + 1'b1;
          end
        end
`ifdef MEM_FILL_VERIFY_EN
        VRFY: begin
          if (at_last) begin
            i     <= '0;
            state <= VDRAIN;
          end else begin
            i <= i + 1'b1;
          end
        end
        VDRAIN: state <= DONE;
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign write_enable = (state == FILL);
  assign done         = (state == DONE);
  assign address      = i;
  assign data         = write_enable ? pat_word : '0;

`ifdef MEM_FILL_VERIFY_EN
  // Read data lags the address by one cycle, so the comparator checks q
  // against the pattern of the address issued in the previous cycle.
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              error_q;
  logic [ADDR_W-1:0] err_addr_q;

  // The generator is shared: FILL uses the live counter, verify the lagged one.
  assign pat_idx = (state == FILL) ? i : cmp_addr;

  always_ff @(posedge clk or posedge reset_task) begin
    if (reset_task) begin
      cmp_vld    <= 1'b0;
      cmp_addr   <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      cmp_vld  <= (state == VRFY) && !abort;
      cmp_addr <= i;
      if (state == IDLE && start && !abort) begin
        error_q    <= 1'b0;
        err_addr_q <= '0;
      end else if (cmp_vld && !abort && !error_q && (q != pat_word)) begin
        // only the first mismatch is recorded
        error_q    <= 1'b1;
        err_addr_q <= cmp_addr;
      end
    end
  end

  assign error    = error_q;
  assign err_addr = err_addr_q;
`else
  logic unused_q;
  assign unused_q = ^q;
  assign pat_idx  = i;
  assign error    = 1'b0;
  assign err_addr = '0;
`endif

  mem_fill_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_pattern (
    .idx        (pat_idx),
    .mode       (mode_q),
    .fill_value (fill_q),
    .word       (pat_word)
  );

endmodule

// File: tb/tb_mem_fill_engine.sv
// tb_mem_fill_engine: checks two engine instances (256-deep full range and
// 16-deep in a 32-word address space) against a cycle-offset job model, with
// directed scenarios followed by randomized start/abort/mode traffic.
module tb_mem_fill_engine;

`ifdef MEM_FILL_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_task = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] fill_value = 8'd0;
  bit         corrupt_en = 1'b0;

  logic [7:0] q0, q1, data0, data1, addr0, err_addr0;
  logic [4:0] addr1, err_addr1;
  logic       we0, we1, busy0, busy1, done0, done1, error0, error1;

  mem_fill_engine #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) u_dut0 (
    .clk(clk), .reset_task(reset_task), .start(start), .abort(abort),
    .mode(mode), .fill_value(fill_value), .q(q0),
    .address(addr0), .data(data0), .write_enable(we0), .busy(busy0),
    .done(done0), .error(error0), .err_addr(err_addr0));

  mem_fill_engine #(.ADDR_W(5), .DATA_W(8), .DEPTH(16)) u_dut1 (
    .clk(clk), .reset_task(reset_task), .start(start), .abort(abort),
    .mode(mode), .fill_value(fill_value), .q(q1),
    .address(addr1), .data(data1), .write_enable(we1), .busy(busy1),
    .done(done1), .error(error1), .err_addr(err_addr1));

  // Per-instance views so the model and RAM can loop over both.
  int         dep [2] = '{256, 16};
  logic [7:0] o_addr [2], o_data [2], o_erra [2], qv [2];
  logic       o_we [2], o_busy [2], o_done [2], o_err [2];
  assign o_addr[0] = addr0;  assign o_addr[1] = {3'b000, addr1};
  assign o_data[0] = data0;  assign o_data[1] = data1;
  assign o_erra[0] = err_addr0; assign o_erra[1] = {3'b000, err_addr1};
  assign o_we[0] = we0;      assign o_we[1] = we1;
  assign o_busy[0] = busy0;  assign o_busy[1] = busy1;
  assign o_done[0] = done0;  assign o_done[1] = done1;
  assign o_err[0] = error0;  assign o_err[1] = error1;
  assign q0 = qv[0];
  assign q1 = qv[1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // RAM models: single port, write on strobe, 1-cycle read latency.
  // Address 37 of the 256-deep RAM can be forced to store 0x00.
  logic [7:0] mem [2][256];
  always @(posedge clk) begin
    for (int x = 0; x < 2; x++) begin
      if (o_we[x]) begin
        chk("wr_range", int'(int'(o_addr[x]) < dep[x]), 1);
        mem[x][o_addr[x]] <= (corrupt_en && x == 0 && o_addr[x] == 8'd37) ? 8'h00 : o_data[x];
      end
      qv[x] <= mem[x][o_addr[x]];
    end
  end

  // ---------------- behavioural model ----------------
  // A job is the accepted start edge k plus latched mode/value. Everything
  // else follows from the offset t of the current cycle (t=1 is the first
  // write), the job length and the RAM contents.
  bit m_act [2];
  int m_k [2], m_mode [2], m_fill [2];
  bit m_errk [2];
  int m_errv [2], m_erra [2];
  int cyc = 0;
  int tm;

  function automatic int pat(input int x, input int idx);
    case (m_mode[x])
      1:       return m_fill[x];
      2:       return dep[x] - 1 - idx;
      default: return idx;
    endcase
  endfunction

  function automatic int jlen(input int x);
    return VER ? 2 * dep[x] + 2 : dep[x] + 1;
  endfunction

  // Verify outcome: first word in the RAM that differs from its pattern.
  function automatic void first_bad(input int x, output int v, output int a);
    v = 0;
    a = 0;
    if (VER)
      for (int j = 0; j < dep[x]; j++)
        if (v == 0 && int'(mem[x][j]) != pat(x, j)) begin
          v = 1;
          a = j;
        end
  endfunction

  always @(posedge clk or posedge reset_task) begin
    if (reset_task) begin
      for (int x = 0; x < 2; x++) begin
        m_act[x] = 1'b0;
        m_errk[x] = 1'b1;
        m_errv[x] = 0;
        m_erra[x] = 0;
      end
    end else begin
      cyc++;
      for (int x = 0; x < 2; x++) begin
        if (m_act[x]) begin
          tm = cyc - m_k[x];          // offset of the cycle this edge ends
          if (abort) begin
            m_act[x] = 1'b0;
            if (tm > dep[x]) m_errk[x] = 1'b0;   // verify partly done
          end else if (tm == jlen(x)) begin
            m_act[x] = 1'b0;
            first_bad(x, m_errv[x], m_erra[x]);
          end
        end else if (start && !abort) begin
          m_act[x]  = 1'b1;
          m_k[x]    = cyc;
          m_mode[x] = int'(mode);
          m_fill[x] = int'(fill_value);
          m_errk[x] = 1'b1;
          m_errv[x] = 0;
          m_erra[x] = 0;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  int ct, ev, ea;
  always @(negedge clk) begin
    if (!reset_task) begin
      for (int x = 0; x < 2; x++) begin
        if (m_act[x]) begin
          ct = cyc - m_k[x] + 1;
          chk("busy", int'(o_busy[x]), 1);
          chk("we", int'(o_we[x]), int'(ct <= dep[x]));
          chk("done", int'(o_done[x]), int'(ct == jlen(x)));
          if (ct <= dep[x]) begin
            chk("fill_addr", int'(o_addr[x]), ct - 1);
            chk("fill_data", int'(o_data[x]), pat(x, ct - 1));
            chk("err_during_fill", int'(o_err[x]), 0);
          end
          if (VER && ct > dep[x] && ct <= 2 * dep[x])
            chk("vrfy_addr", int'(o_addr[x]), ct - dep[x] - 1);
          if (ct == jlen(x)) begin
            first_bad(x, ev, ea);
            chk("done_error", int'(o_err[x]), ev);
            chk("done_err_addr", int'(o_erra[x]), ea);
          end
        end else begin
          chk("idle_busy", int'(o_busy[x]), 0);
          chk("idle_we", int'(o_we[x]), 0);
          chk("idle_done", int'(o_done[x]), 0);
          if (m_errk[x]) begin
            chk("idle_error", int'(o_err[x]), m_errv[x]);
            chk("idle_err_addr", int'(o_erra[x]), m_erra[x]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr0"}, int'(addr0), 0);   chk({tag, "_addr1"}, int'(addr1), 0);
    chk({tag, "_data0"}, int'(data0), 0);   chk({tag, "_data1"}, int'(data1), 0);
    chk({tag, "_we0"}, int'(we0), 0);       chk({tag, "_we1"}, int'(we1), 0);
    chk({tag, "_busy0"}, int'(busy0), 0);   chk({tag, "_busy1"}, int'(busy1), 0);
    chk({tag, "_done0"}, int'(done0), 0);   chk({tag, "_done1"}, int'(done1), 0);
    chk({tag, "_err0"}, int'(error0), 0);   chk({tag, "_err1"}, int'(error1), 0);
    chk({tag, "_erra0"}, int'(err_addr0), 0); chk({tag, "_erra1"}, int'(err_addr1), 0);
  endtask

  // Pulse start and return the 256-deep instance's start-to-done latency
  // (1 = the first write cycle). Optionally scrambles fill_value mid-job.
  task automatic run_job(input int md, input int fv, input bit jitter, output int lat);
    mode = 2'(md);
    fill_value = 8'(fv);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    if (jitter) fill_value = 8'($urandom);
    #3;
    chk("first_addr0", int'(addr0), 0);
    chk("first_we0", int'(we0), 1);
    lat = 1;
    while (!done0 && lat < 1000) begin
      @(posedge clk);
      #2;
      if (jitter) fill_value = 8'($urandom);
      #3;
      lat++;
    end
    tick(1);
  endtask

  int lat, bad, dn;

  initial begin
    for (int x = 0; x < 2; x++)
      for (int a = 0; a < 256; a++) mem[x][a] = 8'hEE;

    @(posedge clk);
    #1;
    chk_zero("reset");
    tick(1);
    reset_task = 1'b0;
    tick(2);

    // IDENT, full 256-word range
    run_job(0, 0, 1'b0, lat);
    chk("ident_latency", lat, VER ? 514 : 257);
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[0][a] != 8'(a)) bad++;
    chk("ident_ram_bad", bad, 0);
    chk("ident_ram255", int'(mem[0][255]), 255);
    chk("ident16_ram15", int'(mem[1][15]), 15);

    // DESC: 16-deep instance must stop at 15 inside a 32-word space
    run_job(2, 0, 1'b0, lat);
    chk("desc16_ram0", int'(mem[1][0]), 15);
    chk("desc16_ram15", int'(mem[1][15]), 0);
    chk("desc16_ram16_untouched", int'(mem[1][16]), 8'hEE);
    chk("desc16_ram31_untouched", int'(mem[1][31]), 8'hEE);
    chk("desc_ram0", int'(mem[0][0]), 255);
    chk("desc_ram255", int'(mem[0][255]), 0);

    // CONST with fill_value changing every cycle after the start edge
    run_job(1, 8'hA5, 1'b1, lat);
    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[0][a] != 8'hA5) bad++;
    chk("const_ram_bad", bad, 0);
    chk("const16_ram3", int'(mem[1][3]), 8'hA5);

    // abort while address 100 is being written
    mode = 2'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(100);
    abort = 1'b1;
    #3;
    chk("abort_at_addr", int'(addr0), 100);
    chk("abort_at_we", int'(we0), 1);
    tick(1);
    abort = 1'b0;
    #3;
    chk("abort_we_low", int'(we0), 0);
    chk("abort_busy_low", int'(busy0), 0);
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dn += int'(done0);
    end
    chk("abort_no_done", dn, 0);
    tick(1);
    run_job(0, 0, 1'b0, lat);
    chk("refill_latency", lat, VER ? 514 : 257);

    // corrupted word 37 seen by read-back verify
    corrupt_en = 1'b1;
    run_job(0, 0, 1'b0, lat);
    corrupt_en = 1'b0;
    chk("corrupt_latency", lat, VER ? 514 : 257);
    chk("corrupt_ram37", int'(mem[0][37]), 0);
    chk("corrupt_error", int'(error0), VER ? 1 : 0);
    chk("corrupt_err_addr", int'(err_addr0), VER ? 37 : 0);
    chk("corrupt_error16", int'(error1), 0);

    // start during busy is ignored; async reset mid-fill clears everything
    mode = 2'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    #3;
    chk("start_busy_ignored", int'(addr0), 21);
    @(posedge clk);
    #3;
    reset_task = 1'b1;
    #1;
    chk_zero("async_reset");
    tick(2);
    reset_task = 1'b0;
    tick(3);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      mode = 2'($urandom_range(0, 3));
      fill_value = 8'($urandom);
      start = 1'b1;
      for (int c = $urandom_range(5, 600); c > 0; c--) begin
        tick(1);
        start = ($urandom_range(0, 40) == 0);
        abort = ($urandom_range(0, 300) == 0);
        fill_value = 8'($urandom);
        mode = 2'($urandom_range(0, 3));
      end
      start = 1'b0;
      abort = 1'b0;
      dn = 0;
      while ((busy0 || busy1) && dn < 700) begin
        tick(1);
        dn++;
      end
      chk("idle_timeout", int'(busy0 || busy1), 0);
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
